// File: rtl/button_debouncer.sv
// Two-channel push-button debouncer for the Up/Down buttons.
// Each raw, bouncing, active-low button passes through a two-flop
// synchroniser and then a four-state stability filter. The debounced
// level only follows the synchronised input once that input has held
// its new level for MaxCount consecutive clock cycles. A one-cycle
// press strobe accompanies every debounced 1->0 transition.

// Single-channel filter: synchroniser plus stability FSM.
module button_debouncer_channel #(
    parameter int MaxCount = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,    // raw button, 0 = pressed, asynchronous
    output logic level_n_o,  // debounced level, 0 = pressed
    output logic press_o     // one-cycle strobe on debounced press
);

    localparam int CntW = $clog2(MaxCount + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MaxCount - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        Released,
        PressPending,
        Pressed,
        ReleasePending
    } state_e;

    logic [1:0]      sync_q;
    logic            btn_sync;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;
    logic            press_q;

    // Two-flop synchroniser; no logic between the stages so the first
    // flop has a full cycle to resolve metastability.
    // NOTE: reset to 1 (released) so a held button after reset is seen
    // as a fresh press and takes the full debounce latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignment so both stages sample the
            // pre-edge values and the chain really is two flops deep.
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

    assign btn_sync = sync_q[1];

    // Stability filter: the output flips only after MaxCount consecutive
    // samples at the new level; any bounce restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Released;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            // The strobe is cleared every cycle unless a press completes,
            // so it can never stay high for two consecutive cycles.
            press_q <= 1'b0;
            unique case (state_q)
                Released: begin
                    level_q <= 1'b1;
                    if (!btn_sync) begin
                        state_q <= PressPending;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PressPending: begin
                    if (btn_sync) begin
                        state_q <= Released;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= Pressed;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CntOne;
                    end
                end
                Pressed: begin
                    level_q <= 1'b0;
                    if (btn_sync) begin
                        state_q <= ReleasePending;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ReleasePending: begin
                    if (!btn_sync) begin
                        state_q <= Pressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= Released;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= Released;
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                end
            endcase
        end
    end

    assign level_n_o = level_q;
    assign press_o   = press_q;

endmodule

// Top level: two independent channels sharing clock and reset.
module button_debouncer #(
    parameter int ClockPeriod_ns      = 20,
    parameter int DebounceInterval_ns = 20_000_000
) (
    input  logic Clock,
    input  logic nReset,
    input  logic iUp,
    input  logic iDown,
    output logic oUp,
    output logic oDown,
    output logic oUpPress,
    output logic oDownPress
);

    localparam int MaxCount = DebounceInterval_ns / ClockPeriod_ns;

    // A filter shorter than two cycles cannot tell a bounce from a press.
    generate
        if (MaxCount < 2) begin : g_bad_interval
            $error("button_debouncer: MaxCount must be at least 2");
        end
    endgenerate

    button_debouncer_channel #(
        .MaxCount (MaxCount)
    ) u_up (
        .clk       (Clock),
        .rst_n     (nReset),
        .btn_n_i   (iUp),
        .level_n_o (oUp),
        .press_o   (oUpPress)
    );

    button_debouncer_channel #(
        .MaxCount (MaxCount)
    ) u_down (
        .clk       (Clock),
        .rst_n     (nReset),
        .btn_n_i   (iDown),
        .level_n_o (oDown),
        .press_o   (oDownPress)
    );

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (MaxCount = 5).
// The reference model treats each channel as: the filter sees the raw
// input two edges late, and the output flips once it has seen MaxCount
// consecutive samples that differ from the current output.
module tb_button_debouncer;

    localparam int MaxCount = 5;

    logic Clock = 1'b0;
    logic nReset;
    logic iUp;
    logic iDown;
    logic oUp;
    logic oDown;
    logic oUpPress;
    logic oDownPress;

    int total = 0;
    int bad   = 0;

    // Reference model state per channel (0 = Up, 1 = Down).
    logic m_d1  [2];
    logic m_d2  [2];
    logic m_out [2];
    logic m_str [2];
    int   m_run [2];

    button_debouncer #(
        .ClockPeriod_ns      (20),
        .DebounceInterval_ns (100)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .iUp        (iUp),
        .iDown      (iDown),
        .oUp        (oUp),
        .oDown      (oDown),
        .oUpPress   (oUpPress),
        .oDownPress (oDownPress)
    );

    always #10 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_d1[c]  = 1'b1;
            m_d2[c]  = 1'b1;
            m_out[c] = 1'b1;
            m_str[c] = 1'b0;
            m_run[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        logic raw [2];
        logic s;
        raw[0] = iUp;
        raw[1] = iDown;
        for (int c = 0; c < 2; c++) begin
            s        = m_d2[c];
            m_d2[c]  = m_d1[c];
            m_d1[c]  = raw[c];
            m_str[c] = 1'b0;
            if (s != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == MaxCount) begin
                    m_out[c] = s;
                    m_run[c] = 0;
                    m_str[c] = (s == 1'b0);
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endfunction

    function automatic int outs();
        return int'({oUp, oDown, oUpPress, oDownPress});
    endfunction

    function automatic int model_outs();
        return int'({m_out[0], m_out[1], m_str[0], m_str[1]});
    endfunction

    // One clock cycle: advance the model at the edge, compare 1 ns later,
    // then return to the falling edge where inputs are changed.
    task automatic cyc(input string tag);
        @(posedge Clock);
        if (nReset) model_edge();
        else        model_reset();
        #1;
        check(tag, outs(), model_outs());
        @(negedge Clock);
    endtask

    int fall_k;
    int rise_k;
    int down_k;
    int up_str;
    int dn_str;
    int both_str;
    int hold_up;
    int hold_dn;

    initial begin
        iUp    = 1'b1;
        iDown  = 1'b1;
        nReset = 1'b1;
        model_reset();
        @(negedge Clock);

        // 1. Reset with both buttons held: outputs stay released.
        nReset = 1'b0;
        iUp    = 1'b0;
        iDown  = 1'b0;
        #1;
        check("rst_async_vals", outs(), 4'b1100);
        @(negedge Clock);
        for (int i = 0; i < 6; i++) cyc("rst_hold");
        check("rst_state", outs(), 4'b1100);

        // Release reset with buttons held; wait for the debounced press.
        nReset = 1'b1;
        fall_k = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("rst_rel_press");
            if (oUp == 1'b0 && fall_k == 0) fall_k = k;
        end
        check("rst_rel_latency", fall_k, 7);

        // Asynchronous reset mid-cycle while pressed.
        #3;
        nReset = 1'b0;
        model_reset();
        #1;
        check("rst_async_midcycle", outs(), 4'b1100);
        cyc("rst_async_hold");
        iUp   = 1'b1;
        iDown = 1'b1;
        cyc("rst_async_hold");
        nReset = 1'b1;
        for (int i = 0; i < 8; i++) cyc("idle");

        // 2. Clean press on Up only.
        iUp    = 1'b0;
        fall_k = 0;
        up_str = 0;
        dn_str = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("clean_press");
            if (oUp == 1'b0 && fall_k == 0) fall_k = k;
            up_str += int'(oUpPress);
            dn_str += int'(oDownPress) + int'(!oDown);
        end
        check("clean_latency", fall_k, 7);
        check("clean_strobes", up_str, 1);
        check("clean_down_idle", dn_str, 0);

        // Release and settle before the bounce test.
        iUp = 1'b1;
        for (int i = 0; i < 10; i++) cyc("release_settle");

        // 3. Bounce rejection on press.
        up_str = 0;
        for (int r = 0; r < 4; r++) begin
            iUp = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cyc("bounce_press");
                up_str += int'(oUpPress);
            end
            iUp = 1'b1;
            cyc("bounce_press");
            up_str += int'(oUpPress);
        end
        check("bounce_no_change", int'(oUp), 1);
        iUp    = 1'b0;
        fall_k = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("bounce_settle");
            if (oUp == 1'b0 && fall_k == 0) fall_k = k;
            up_str += int'(oUpPress);
        end
        check("bounce_latency", fall_k, 7);
        check("bounce_strobes", up_str, 1);

        // 4. Release with bounce.
        up_str = 0;
        iUp    = 1'b1;
        for (int i = 0; i < 4; i++) cyc("bounce_release");
        iUp = 1'b0;
        cyc("bounce_release");
        check("release_held_low", int'(oUp), 0);
        iUp    = 1'b1;
        rise_k = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("release_settle");
            if (oUp == 1'b1 && rise_k == 0) rise_k = k;
            up_str += int'(oUpPress);
        end
        check("release_latency", rise_k, 7);
        check("release_no_strobe", up_str, 0);

        // 5. Simultaneous press on both channels.
        iUp      = 1'b0;
        iDown    = 1'b0;
        fall_k   = 0;
        down_k   = 0;
        both_str = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("simul_press");
            if (oUp == 1'b0 && fall_k == 0)   fall_k = k;
            if (oDown == 1'b0 && down_k == 0) down_k = k;
            both_str += int'(oUpPress && oDownPress);
        end
        check("simul_up_latency", fall_k, 7);
        check("simul_down_latency", down_k, 7);
        check("simul_shared_strobe", both_str, 1);

        iUp   = 1'b1;
        iDown = 1'b1;
        for (int i = 0; i < 10; i++) cyc("simul_release");

        // 6. Reset mid-pending on Down.
        iDown = 1'b0;
        cyc("pend_rst");
        cyc("pend_rst");
        nReset = 1'b0;
        cyc("pend_rst_low");
        check("pend_rst_level", int'(oDown), 1);
        nReset = 1'b1;
        down_k = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("pend_rst_after");
            if (oDown == 1'b0 && down_k == 0) down_k = k;
        end
        check("pend_rst_latency", down_k, 7);

        // Randomised phase: random hold lengths straddling MaxCount plus
        // occasional resets, all checked against the model every cycle.
        iUp     = 1'b1;
        iDown   = 1'b1;
        hold_up = 0;
        hold_dn = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_up == 0) begin
                iUp     = ~iUp;
                hold_up = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                      : int'($urandom_range(1, 7));
            end
            if (hold_dn == 0) begin
                iDown   = ~iDown;
                hold_dn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                      : int'($urandom_range(1, 7));
            end
            hold_up--;
            hold_dn--;
            nReset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            cyc("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
